// File: rtl/shmem_arb_pkg.sv
// Shared types and default sizing for the shared-memory arbiter slice.
package shmem_arb_pkg;

  localparam int unsigned DEF_N_CORES = 16;
  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OP_LD = 1'b0,
    OP_ST = 1'b1
  } op_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shmem_rr_picker.sv
// Combinational winner selection among eligible cores.
// SHMEM_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores the pointer.
module shmem_rr_picker
  import shmem_arb_pkg::*;
#(
  parameter int unsigned N_CORES = DEF_N_CORES,
  parameter int unsigned IDX_W   = idx_w(N_CORES)
) (
  input  logic [N_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx_s;

`ifdef SHMEM_ARB_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
`endif

  // Scan candidates in priority order; the first eligible one wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_s  = '0;
    for (int i = 0; i < int'(N_CORES); i++) begin
`ifdef SHMEM_ARB_FIXED_PRIO_EN
      idx_s = IDX_W'(i);
`else
      idx_s = IDX_W'((int'(ptr) + i) % int'(N_CORES));
`endif
      winner = (!found && eligible[idx_s]) ? idx_s : winner;
      found  = found | eligible[idx_s];
    end
  end

endmodule

// File: rtl/shmem_arbiter.sv
// Serialises per-core load/store requests onto one single-port SM macro.
// Optional macro SHMEM_ARB_FIXED_PRIO_EN: fixed lowest-index priority, no rr pointer.
module shmem_arbiter
  import shmem_arb_pkg::*;
#(
  parameter int unsigned N_CORES = DEF_N_CORES,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        mem_req_ld,
  input  logic [N_CORES-1:0]        mem_req_st,
  input  logic [N_CORES*ADDR_W-1:0] addr_shared_memory,
  input  logic [N_CORES*DATA_W-1:0] mem_dat_st,
  output logic [N_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]         mem_dat,
  output logic                      sm_en,
  output logic                      sm_we,
  output logic [ADDR_W-1:0]         sm_addr,
  output logic [DATA_W-1:0]         sm_wdata,
  input  logic [DATA_W-1:0]         sm_rdata,
  output logic                      busy,
  output logic                      err_conflict
);

  localparam int unsigned IDX_W = idx_w(N_CORES);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [N_CORES-1:0]   val_q, val_d;
  logic [DATA_W-1:0]    mem_dat_q, mem_dat_d;
  logic                 sm_en_q, sm_en_d;
  logic                 sm_we_q, sm_we_d;
  logic [ADDR_W-1:0]    sm_addr_q, sm_addr_d;
  logic [DATA_W-1:0]    sm_wdata_q, sm_wdata_d;
  logic                 err_q, err_d;
  logic [N_CORES-1:0]   eligible_s;
  logic [IDX_W-1:0]     ptr_s;
  logic [IDX_W-1:0]     win_s;
  logic                 found_s;

`ifndef SHMEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
  assign ptr_s = rr_q;
`else
  assign ptr_s = '0;
`endif

  assign eligible_s = mem_req_ld | mem_req_st;

  shmem_rr_picker #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .eligible (eligible_s),
    .ptr      (ptr_s),
    .found    (found_s),
    .winner   (win_s)
  );

  // Next-state and output computation for the grant/access/capture/response sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    g_d        = g_q;
    val_d      = '0;
    mem_dat_d  = mem_dat_q;
    sm_en_d    = 1'b0;
    sm_we_d    = 1'b0;
    sm_addr_d  = sm_addr_q;
    sm_wdata_d = sm_wdata_q;
    err_d      = err_q;
`ifndef SHMEM_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = ACCESS;
          g_d        = win_s;
          op_d       = mem_req_st[win_s] ? OP_ST : OP_LD;
          sm_en_d    = 1'b1;
          sm_we_d    = mem_req_st[win_s];
          sm_addr_d  = addr_shared_memory[int'(win_s)*int'(ADDR_W) +: ADDR_W];
          sm_wdata_d = mem_dat_st[int'(win_s)*int'(DATA_W) +: DATA_W];
          // A core raising both strobes is served as a store and flagged.
          err_d      = err_q | (mem_req_ld[win_s] & mem_req_st[win_s]);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        mem_dat_d = (op_q == OP_LD) ? sm_rdata : mem_dat_q;
        val_d     = {{(N_CORES-1){1'b0}}, 1'b1} << g_q;
        state_d   = RESP;
      end
      RESP: begin
`ifndef SHMEM_ARB_FIXED_PRIO_EN
        rr_d    = (g_q == IDX_W'(N_CORES-1)) ? '0 : g_q + IDX_W'(1);
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_LD;
      g_q        <= '0;
      val_q      <= '0;
      mem_dat_q  <= '0;
      sm_en_q    <= 1'b0;
      sm_we_q    <= 1'b0;
      sm_addr_q  <= '0;
      sm_wdata_q <= '0;
      err_q      <= 1'b0;
`ifndef SHMEM_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      g_q        <= g_d;
      val_q      <= val_d;
      mem_dat_q  <= mem_dat_d;
      sm_en_q    <= sm_en_d;
      sm_we_q    <= sm_we_d;
      sm_addr_q  <= sm_addr_d;
      sm_wdata_q <= sm_wdata_d;
      err_q      <= err_d;
`ifndef SHMEM_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign val_data     = val_q;
  assign mem_dat      = mem_dat_q;
  assign sm_en        = sm_en_q;
  assign sm_we        = sm_we_q;
  assign sm_addr      = sm_addr_q;
  assign sm_wdata     = sm_wdata_q;
  assign err_conflict = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_shmem_arbiter.sv
// Scoreboard bench: transaction-level arbitration model feeds expected queues, a monitor checks.
module tb_shmem_arbiter;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mem_req_ld, mem_req_st;
  logic [N*AW-1:0] addr_shared_memory;
  logic [N*DW-1:0] mem_dat_st;
  logic [N-1:0]    val_data;
  logic [DW-1:0]   mem_dat;
  logic            sm_en, sm_we;
  logic [AW-1:0]   sm_addr;
  logic [DW-1:0]   sm_wdata, sm_rdata;
  logic            busy, err_conflict;

  shmem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .mem_req_ld(mem_req_ld), .mem_req_st(mem_req_st),
    .addr_shared_memory(addr_shared_memory), .mem_dat_st(mem_dat_st),
    .val_data(val_data), .mem_dat(mem_dat), .sm_en(sm_en), .sm_we(sm_we),
    .sm_addr(sm_addr), .sm_wdata(sm_wdata), .sm_rdata(sm_rdata),
    .busy(busy), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  // SM macro behaviour: synchronous write, read data one cycle after the access.
  logic [DW-1:0] sm_arr  [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sm_en) begin
      if (sm_we) sm_arr[sm_addr] <= sm_wdata;
      else       sm_rdata <= sm_arr[sm_addr];
    end
  end

  typedef struct {
    int            cyc;
    int            core;
    bit            st;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sm_q[$];
  exp_t          resp_q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            free_at = 0;
  int            dec_cyc = -10;
  int            dec_core = 0;
  int            ptr = 0;
  int            err_cyc = 1 << 30;
  bit            mon_en = 1'b0;
  logic [DW-1:0] exp_mem_dat = '0;
  bit            pend [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the expected-transaction queues every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] oh;
    if (mon_en) begin
      while (sm_q.size() > 0 && sm_q[0].cyc < cyc) begin
        e = sm_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL sm_access_missing core %0d: got none expected at cycle %0d", e.core, e.cyc);
      end
      while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        e = resp_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL val_data_missing core %0d: got none expected at cycle %0d", e.core, e.cyc);
      end
      if (sm_q.size() > 0 && sm_q[0].cyc == cyc) begin
        e = sm_q.pop_front();
        chk("sm_en", 32'(sm_en), 32'd1);
        chk("sm_we", 32'(sm_we), 32'(e.st));
        chk("sm_addr", 32'(sm_addr), 32'(e.addr));
        if (e.st) chk("sm_wdata", 32'(sm_wdata), 32'(e.data));
      end else begin
        chk("sm_en_quiet", 32'(sm_en), 32'd0);
      end
      if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
        e = resp_q.pop_front();
        oh = '0;
        oh[e.core] = 1'b1;
        if (!e.st) exp_mem_dat = e.data;
        chk("val_data", 32'(val_data), 32'(oh));
        chk("mem_dat", 32'(mem_dat), 32'(exp_mem_dat));
      end else begin
        chk("val_data_quiet", 32'(val_data), 32'd0);
        chk("mem_dat_hold", 32'(mem_dat), 32'(exp_mem_dat));
      end
      chk("busy", 32'(busy), 32'(cyc > dec_cyc && cyc <= dec_cyc + 3));
      chk("err_conflict", 32'(err_conflict), 32'(cyc > err_cyc));
    end
  end

  task automatic set_req(input int k, input bit ld, input bit st,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_req_ld[k] = ld;
    mem_req_st[k] = st;
    addr_shared_memory[k*AW +: AW] = a;
    mem_dat_st[k*DW +: DW] = d;
    pend[k] = ld | st;
  endtask

  task automatic drop_req(input int k);
    mem_req_ld[k] = 1'b0;
    mem_req_st[k] = 1'b0;
    pend[k] = 1'b0;
  endtask

  // Advance to the next sampling point; the served core releases its request there.
  task automatic adv();
    @(negedge clk);
    if (cyc == dec_cyc + 3) drop_req(dec_core);
  endtask

  // Reference model: one grant per free slot, round-robin from the pointer, 4-cycle spacing.
  task automatic decide();
    logic [N-1:0]  elig;
    int            w;
    bit            st;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    elig = mem_req_ld | mem_req_st;
    if (cyc >= free_at && elig != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && elig[(ptr + i) % N]) w = (ptr + i) % N;
      end
      st = mem_req_st[w];
      a  = addr_shared_memory[w*AW +: AW];
      d  = mem_dat_st[w*DW +: DW];
      if (st && mem_req_ld[w] && err_cyc > cyc) err_cyc = cyc;
      if (st) ref_mem[a] = d;
      sm_q.push_back('{cyc + 1, w, st, a, d});
      resp_q.push_back('{cyc + 3, w, st, a, ref_mem[a]});
      dec_cyc  = cyc;
      dec_core = w;
      free_at  = cyc + 4;
`ifdef SHMEM_ARB_FIXED_PRIO_EN
      ptr = 0;
`else
      ptr = (w + 1) % N;
`endif
    end
  endtask

  task automatic rand_issue();
    bit op;
    if (cyc == dec_cyc + 1 && $urandom_range(0, 3) == 0) drop_req(dec_core);
    for (int k = 0; k < N; k++) begin
      if (!pend[k] && !(k == dec_core && cyc <= dec_cyc + 3) && $urandom_range(0, 7) == 0) begin
        op = 1'($urandom_range(0, 1));
        set_req(k, !op, op, 12'($urandom_range(0, 63)), 8'($urandom));
      end
    end
  endtask

  task automatic step(input bit rnd);
    adv();
    if (rnd) rand_issue();
    decide();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_val_data"}, 32'(val_data), 32'd0);
    chk({tag, "_mem_dat"}, 32'(mem_dat), 32'd0);
    chk({tag, "_sm_en"}, 32'(sm_en), 32'd0);
    chk({tag, "_sm_we"}, 32'(sm_we), 32'd0);
    chk({tag, "_sm_addr"}, 32'(sm_addr), 32'd0);
    chk({tag, "_sm_wdata"}, 32'(sm_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_conflict), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = 8'($urandom);
      sm_arr[i]  = v;
      ref_mem[i] = v;
    end
    sm_arr[12'h2A5]  = 8'h5C;
    ref_mem[12'h2A5] = 8'h5C;
    reset = 1'b0;
    mem_req_ld = '0;
    mem_req_st = '0;
    addr_shared_memory = '0;
    mem_dat_st = '0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset   = 1'b1;
    free_at = cyc;
    mon_en  = 1'b1;

    // Single load from core 3.
    adv(); set_req(3, 1'b1, 1'b0, 12'h2A5, 8'h00); decide();
    repeat (6) step(1'b0);
    chk("single_load_data", 32'(mem_dat), 32'h5C);

    // Store then load through core 0.
    adv(); set_req(0, 1'b0, 1'b1, 12'h010, 8'hA7); decide();
    repeat (5) step(1'b0);
    adv(); set_req(0, 1'b1, 1'b0, 12'h010, 8'h00); decide();
    repeat (5) step(1'b0);
    chk("store_load_data", 32'(mem_dat), 32'hA7);

    // Contention among cores 1, 5, 15; core 1 re-requests while the others wait.
    adv();
    set_req(1, 1'b1, 1'b0, 12'h011, 8'h00);
    set_req(5, 1'b0, 1'b1, 12'h012, 8'h5A);
    set_req(15, 1'b1, 1'b0, 12'h012, 8'h00);
    decide();
    for (int i = 0; i < 24; i++) begin
      adv();
      if (i == 5 && !pend[1]) set_req(1, 1'b1, 1'b0, 12'h013, 8'h00);
      decide();
    end

    // Pointer wrap: serve core 14, then cores 0 and 15 together.
    adv(); set_req(14, 1'b1, 1'b0, 12'h020, 8'h00); decide();
    repeat (6) step(1'b0);
    adv();
    set_req(0, 1'b1, 1'b0, 12'h021, 8'h00);
    set_req(15, 1'b0, 1'b1, 12'h021, 8'hC3);
    decide();
    repeat (12) step(1'b0);

    // Randomised traffic, then drain.
    repeat (800) step(1'b1);
    repeat (90) step(1'b0);

    // Load/store conflict on core 2.
    adv(); set_req(2, 1'b1, 1'b1, 12'h123, 8'h3C); decide();
    repeat (6) step(1'b0);
    chk("conflict_err", 32'(err_conflict), 32'd1);
    chk("conflict_store", 32'(sm_arr[12'h123]), 32'h3C);

    // Reset while in CAPTURE aborts the access.
    adv(); set_req(2, 1'b1, 1'b0, 12'h2A5, 8'h00); decide();
    adv();
    mon_en = 1'b0;
    adv();
    reset       = 1'b0;
    dec_cyc     = -10;
    err_cyc     = 1 << 30;
    exp_mem_dat = '0;
    sm_q.delete();
    resp_q.delete();
    adv();
    check_reset_outputs("abort");
    reset   = 1'b1;
    ptr     = 0;
    free_at = cyc;
    mon_en  = 1'b1;
    decide();
    repeat (8) step(1'b0);
    chk("abort_regrant_data", 32'(mem_dat), 32'h5C);

    chk("sm_queue_drained", 32'(sm_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
